// File: rtl/memory_access_scheduler.sv
`timescale 1ns/1ps
// memory_access_scheduler: arbitrates CPU, DMA and refresh traffic onto a single memory port.
// Latency: grant on the first IDLE edge that sees a request; mem_request one clock later; ready one clock after mem_ack.
// Backpressure: requesters hold their level until ready; the memory stalls a command by withholding mem_ack.
module memory_access_scheduler #(
  parameter int REFRESH_INTERVAL    = 72,
  parameter int REFRESH_MAX_PENDING = 4,
  parameter int DMA_BURST_LIMIT     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  // CPU requester
  input  logic        cpu_request,
  input  logic        cpu_write,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_data_in,
  output logic        cpu_ready,
  output logic [7:0]  cpu_data_out,
  // DMA requester
  input  logic        dma_request,
  input  logic        dma_write,
  input  logic [19:0] dma_address,
  input  logic [7:0]  dma_data_in,
  output logic        dma_ready,
  output logic [7:0]  dma_data_out,
  // refresh control
  input  logic        refresh_enable,
  // memory port
  output logic        mem_request,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_data_out,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data_in,
  // status
  output logic        busy
);

  localparam int              CNT_W      = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]      PEND_MAX   = 4'(REFRESH_MAX_PENDING);
  localparam logic [1:0]      STREAK_MAX = 2'(DMA_BURST_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CPU_ACCESS = 3'd1,
    ST_DMA_ACCESS = 3'd2,
    ST_REFRESH    = 3'd3,
    ST_COMPLETE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              owner_dma_q, owner_dma_d;   // which requester COMPLETE reports to
  logic              mem_request_q, mem_request_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_refresh_q, mem_refresh_d;
  logic [19:0]       mem_address_q, mem_address_d;
  logic [7:0]        mem_data_out_q, mem_data_out_d;
  logic [7:0]        cpu_data_out_q, cpu_data_out_d;
  logic [7:0]        dma_data_out_q, dma_data_out_d;
  logic [3:0]        pending_q, pending_d;
  logic [7:0]        refresh_row_q, refresh_row_d;
  logic [1:0]        streak_q, streak_d;
  logic [CNT_W-1:0]  refresh_cnt_q, refresh_cnt_d;

  logic              gnt_refresh, gnt_cpu, gnt_dma;
  logic              ack_seen;
  logic              refresh_ack;
  logic              refresh_tick;

  // A command only completes once the memory has actually seen mem_request.
  assign ack_seen    = mem_request_q && mem_ack;
  assign refresh_ack = (state_q == ST_REFRESH) && ack_seen;

  // Fixed-priority arbitration; only acted upon while IDLE.
  always_comb begin
    gnt_refresh = 1'b0;
    gnt_cpu     = 1'b0;
    gnt_dma     = 1'b0;
    if (pending_q == PEND_MAX) begin
      gnt_refresh = 1'b1;                       // refresh backlog is full, it cannot wait
    end else if (cpu_request && (streak_q == STREAK_MAX)) begin
      gnt_cpu = 1'b1;                           // CPU has been starved by DMA long enough
    end else if (dma_request) begin
      gnt_dma = 1'b1;
    end else if (cpu_request) begin
      gnt_cpu = 1'b1;
    end else if (pending_q != 4'd0) begin
      gnt_refresh = 1'b1;                       // opportunistic refresh when the port is free
    end
  end

  // Refresh interval counter and pending-refresh backlog.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    pending_d     = pending_q;
    refresh_tick  = 1'b0;
    if (refresh_enable) begin
      if (refresh_cnt_q == '0) begin
        refresh_cnt_d = CNT_RELOAD;
        refresh_tick  = 1'b1;
      end else begin
        refresh_cnt_d = refresh_cnt_q - 1'b1;
      end
    end
    // A new request and a serviced refresh in the same clock cancel out.
    if (refresh_tick && !refresh_ack) begin
      if (pending_q != PEND_MAX) begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!refresh_tick && refresh_ack) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // Scheduler FSM: grant, hold the memory command until ack, then report completion.
  always_comb begin
    state_d        = state_q;
    owner_dma_d    = owner_dma_q;
    mem_request_d  = mem_request_q;
    mem_write_d    = mem_write_q;
    mem_refresh_d  = mem_refresh_q;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    cpu_data_out_d = cpu_data_out_q;
    dma_data_out_d = dma_data_out_q;
    refresh_row_d  = refresh_row_q;
    streak_d       = streak_q;

    case (state_q)
      ST_IDLE: begin
        if (!cpu_request) begin
          streak_d = 2'd0;
        end
        if (gnt_refresh) begin
          state_d        = ST_REFRESH;
          mem_refresh_d  = 1'b1;
          mem_write_d    = 1'b0;
          mem_address_d  = {12'h000, refresh_row_q};
          mem_data_out_d = 8'h00;
        end else if (gnt_cpu) begin
          state_d        = ST_CPU_ACCESS;
          mem_refresh_d  = 1'b0;
          mem_write_d    = cpu_write;
          mem_address_d  = cpu_address;
          mem_data_out_d = cpu_write ? cpu_data_in : 8'h00;
          streak_d       = 2'd0;
        end else if (gnt_dma) begin
          state_d        = ST_DMA_ACCESS;
          mem_refresh_d  = 1'b0;
          mem_write_d    = dma_write;
          mem_address_d  = dma_address;
          mem_data_out_d = dma_write ? dma_data_in : 8'h00;
          if (cpu_request && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
          end
        end
      end

      ST_CPU_ACCESS, ST_DMA_ACCESS, ST_REFRESH: begin
        if (ack_seen) begin
          mem_request_d = 1'b0;
          if (state_q == ST_REFRESH) begin
            state_d       = ST_IDLE;
            mem_refresh_d = 1'b0;
            refresh_row_d = refresh_row_q + 8'd1;
          end else begin
            state_d     = ST_COMPLETE;
            owner_dma_d = (state_q == ST_DMA_ACCESS);
            if (!mem_write_q) begin
              if (state_q == ST_DMA_ACCESS) begin
                dma_data_out_d = mem_data_in;
              end else begin
                cpu_data_out_d = mem_data_in;
              end
            end
          end
        end else begin
          // First cycle after grant raises the request; later cycles simply hold it.
          mem_request_d = 1'b1;
        end
      end

      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any in-flight command immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      owner_dma_q    <= 1'b0;
      mem_request_q  <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_refresh_q  <= 1'b0;
      mem_address_q  <= 20'h00000;
      mem_data_out_q <= 8'h00;
      cpu_data_out_q <= 8'h00;
      dma_data_out_q <= 8'h00;
      pending_q      <= 4'd0;
      refresh_row_q  <= 8'h00;
      streak_q       <= 2'd0;
      refresh_cnt_q  <= CNT_RELOAD;
    end else begin
      state_q        <= state_d;
      owner_dma_q    <= owner_dma_d;
      mem_request_q  <= mem_request_d;
      mem_write_q    <= mem_write_d;
      mem_refresh_q  <= mem_refresh_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      cpu_data_out_q <= cpu_data_out_d;
      dma_data_out_q <= dma_data_out_d;
      pending_q      <= pending_d;
      refresh_row_q  <= refresh_row_d;
      streak_q       <= streak_d;
      refresh_cnt_q  <= refresh_cnt_d;
    end
  end

  assign cpu_ready    = (state_q == ST_COMPLETE) && !owner_dma_q;
  assign dma_ready    = (state_q == ST_COMPLETE) &&  owner_dma_q;
  assign cpu_data_out = cpu_data_out_q;
  assign dma_data_out = dma_data_out_q;
  assign mem_request  = mem_request_q;
  assign mem_write    = mem_write_q;
  assign mem_refresh  = mem_refresh_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memory_access_scheduler.sv
`timescale 1ns/1ps
// tb_memory_access_scheduler: directed scenarios plus randomized CPU/DMA traffic.
// A memory responder model answers commands; a reference memory predicts read data.
// Grants are logged when busy rises and compared against the arbitration rules.
module tb_memory_access_scheduler;

  localparam int K_CPU = 1;
  localparam int K_DMA = 2;
  localparam int K_REF = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_request = 1'b0, cpu_write = 1'b0;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_data_in = '0;
  logic        cpu_ready;
  logic [7:0]  cpu_data_out;
  logic        dma_request = 1'b0, dma_write = 1'b0;
  logic [19:0] dma_address = '0;
  logic [7:0]  dma_data_in = '0;
  logic        dma_ready;
  logic [7:0]  dma_data_out;
  logic        refresh_enable = 1'b0;
  logic        mem_request, mem_write, mem_refresh;
  logic [19:0] mem_address;
  logic [7:0]  mem_data_out;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data_in = '0;
  logic        busy;

  memory_access_scheduler #(
    .REFRESH_INTERVAL(72), .REFRESH_MAX_PENDING(4), .DMA_BURST_LIMIT(2)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_request(cpu_request), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_data_in(cpu_data_in), .cpu_ready(cpu_ready), .cpu_data_out(cpu_data_out),
    .dma_request(dma_request), .dma_write(dma_write), .dma_address(dma_address),
    .dma_data_in(dma_data_in), .dma_ready(dma_ready), .dma_data_out(dma_data_out),
    .refresh_enable(refresh_enable),
    .mem_request(mem_request), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_ack(mem_ack), .mem_data_in(mem_data_in), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- memory device and reference memory ----------------
  logic [7:0] dev_mem [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] dflt(input logic [19:0] a);
    return a[7:0] ^ 8'h3C ^ {a[19], 7'h00};
  endfunction

  function automatic logic [7:0] dev_rd(input logic [19:0] a);
    return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  int ack_lat    = 1;
  bit hold_ack   = 1'b0;
  bit rand_lat   = 1'b0;
  int req_cycles = 0;

  // Acks on the ack_lat-th cycle that mem_request is seen high.
  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (!reset_n) begin
      req_cycles = 0;
    end else if (mem_request && !hold_ack) begin
      req_cycles++;
      if (req_cycles >= ack_lat) begin
        mem_ack    = 1'b1;
        req_cycles = 0;
        if (mem_write) dev_mem[int'(mem_address)] = mem_data_out;
        mem_data_in = (mem_write || mem_refresh) ? 8'hEE : dev_rd(mem_address);
        if (rand_lat) ack_lat = $urandom_range(1, 4);
      end
    end
  end

  // ---------------- grant log ----------------
  typedef struct {
    int          cyc;
    int          kind;
    logic [19:0] addr;
    logic        wr;
    logic [7:0]  dat;
  } grant_t;
  grant_t grant_log[$];
  bit     prev_busy   = 1'b0;
  bit     rand_mode   = 1'b0;
  int     cpu_dma_run = 0;
  int     dma_rdy_cnt = 0;

  always @(negedge clock) begin
    grant_t g;
    if (busy && !prev_busy) begin
      g.cyc  = cyc;
      g.kind = mem_refresh ? K_REF : (mem_address[19] ? K_DMA : K_CPU);
      g.addr = mem_address;
      g.wr   = mem_write;
      g.dat  = mem_data_out;
      grant_log.push_back(g);
      if (rand_mode) begin
        if (g.kind == K_CPU) begin
          check_eq("cpu_cmd_addr", 32'(mem_address), 32'(cpu_address));
          check_eq("cpu_cmd_wr", 32'(mem_write), 32'(cpu_write));
          check_eq("cpu_cmd_dat", 32'(mem_data_out), cpu_write ? 32'(cpu_data_in) : 32'd0);
          cpu_dma_run = 0;
        end else if (g.kind == K_DMA) begin
          check_eq("dma_cmd_addr", 32'(mem_address), 32'(dma_address));
          check_eq("dma_cmd_wr", 32'(mem_write), 32'(dma_write));
          check_eq("dma_cmd_dat", 32'(mem_data_out), dma_write ? 32'(dma_data_in) : 32'd0);
          if (cpu_request) cpu_dma_run++;
          check_eq("dma_burst_limit", 32'(cpu_dma_run <= 2), 32'd1);
        end
      end
    end
    prev_busy = busy;
    if (dma_ready) dma_rdy_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clock); #1;
    reset_n = 1'b0;
    cpu_request = 1'b0; dma_request = 1'b0; refresh_enable = 1'b0;
    hold_ack = 1'b0; rand_lat = 1'b0; ack_lat = 1; rand_mode = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;
    grant_log.delete();
    cpu_dma_run = 0;
    dma_rdy_cnt = 0;
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    check_eq({tag, "_reached"}, 32'(grant_log.size() >= n), 32'd1);
  endtask

  task automatic xfer(input bit is_dma, input bit wr, input logic [19:0] a,
                      input logic [7:0] d, input string tag);
    int k = 0;
    bit got = 1'b0;
    @(negedge clock); #1;
    if (is_dma) begin
      dma_request = 1'b1; dma_write = wr; dma_address = a; dma_data_in = d;
    end else begin
      cpu_request = 1'b1; cpu_write = wr; cpu_address = a; cpu_data_in = d;
    end
    while (!got && k < 300) begin
      @(negedge clock); #1;
      k++;
      if (is_dma ? dma_ready : cpu_ready) got = 1'b1;
    end
    if (is_dma) dma_request = 1'b0;
    else        cpu_request = 1'b0;
    check_eq({tag, "_ready"}, 32'(got), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int req_n, busy_n, rdy_n, rdy_at, last_req, ref_n;
    logic [7:0] cpu_last, dma_last;

    // Reset state while reset_n is held low.
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_mem_request", 32'(mem_request), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_mem_refresh", 32'(mem_refresh), 32'd0);
    check_eq("rst_mem_address", 32'(mem_address), 32'd0);
    check_eq("rst_mem_data_out", 32'(mem_data_out), 32'd0);
    check_eq("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check_eq("rst_dma_ready", 32'(dma_ready), 32'd0);
    check_eq("rst_cpu_data_out", 32'(cpu_data_out), 32'd0);
    check_eq("rst_dma_data_out", 32'(dma_data_out), 32'd0);
    @(negedge clock); #1;
    reset_n = 1'b1;

    // CPU read of 0x12345, acked on the third request cycle with 0xA5.
    dev_mem[int'(20'h12345)] = 8'hA5;
    ack_lat = 3;
    @(negedge clock); #1;
    cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 20'h12345;
    req_n = 0; busy_n = 0; rdy_n = 0; rdy_at = -1; last_req = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (mem_request) begin req_n++; last_req = i; end
      if (busy) busy_n++;
      if (cpu_ready) begin rdy_n++; rdy_at = i; cpu_request = 1'b0; end
    end
    check_eq("rd_req_cycles", 32'(req_n), 32'd3);
    check_eq("rd_busy_cycles", 32'(busy_n), 32'd5);
    check_eq("rd_ready_pulses", 32'(rdy_n), 32'd1);
    check_eq("rd_ready_after_req", 32'(rdy_at), 32'(last_req + 1));
    check_eq("rd_cpu_data", 32'(cpu_data_out), 32'hA5);
    check_eq("rd_cmd_addr", 32'(grant_log[0].addr), 32'h12345);
    check_eq("rd_cmd_wr", 32'(grant_log[0].wr), 32'd0);
    check_eq("rd_cmd_dat", 32'(grant_log[0].dat), 32'd0);

    // CPU and DMA both held: DMA, DMA, CPU repeating.
    do_reset();
    @(negedge clock); #1;
    cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 20'h00020;
    dma_request = 1'b1; dma_write = 1'b0; dma_address = 20'h80010;
    wait_grants(6, 200, "arb_order");
    cpu_request = 1'b0; dma_request = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("arb_order_%0d", i), 32'(grant_log[i].kind),
               ((i % 3) == 2) ? 32'(K_CPU) : 32'(K_DMA));
    end
    repeat (10) @(negedge clock);

    // Periodic refresh with no requesters; row wraps after 256.
    do_reset();
    refresh_enable = 1'b1;
    wait_grants(257, 257 * 72 + 500, "refresh_run");
    refresh_enable = 1'b0;
    check_eq("ref_kind_0", 32'(grant_log[0].kind), 32'(K_REF));
    check_eq("ref_addr_0", 32'(grant_log[0].addr), 32'h00000);
    check_eq("ref_addr_1", 32'(grant_log[1].addr), 32'h00001);
    check_eq("ref_addr_2", 32'(grant_log[2].addr), 32'h00002);
    check_eq("ref_wr_1", 32'(grant_log[1].wr), 32'd0);
    check_eq("ref_period_1", 32'(grant_log[1].cyc - grant_log[0].cyc), 32'd72);
    check_eq("ref_period_2", 32'(grant_log[2].cyc - grant_log[1].cyc), 32'd72);
    check_eq("ref_period_256", 32'(grant_log[256].cyc - grant_log[255].cyc), 32'd72);
    check_eq("ref_addr_255", 32'(grant_log[255].addr), 32'h000FF);
    check_eq("ref_addr_wrap", 32'(grant_log[256].addr), 32'h00000);

    // Stalled DMA lets the refresh backlog saturate at 4.
    do_reset();
    @(negedge clock); #1;
    dma_request = 1'b1; dma_write = 1'b0; dma_address = 20'h80100;
    refresh_enable = 1'b1;
    hold_ack = 1'b1;
    wait_grants(1, 20, "stall_grant");
    repeat (400) @(negedge clock);
    #1;
    refresh_enable = 1'b0;
    hold_ack = 1'b0;
    wait_grants(3, 50, "stall_release");
    dma_request = 1'b0;
    check_eq("sat_first_dma", 32'(grant_log[0].kind), 32'(K_DMA));
    check_eq("sat_refresh_first", 32'(grant_log[1].kind), 32'(K_REF));
    check_eq("sat_then_dma", 32'(grant_log[2].kind), 32'(K_DMA));
    repeat (100) @(negedge clock);
    ref_n = 0;
    foreach (grant_log[i]) if (grant_log[i].kind == K_REF) ref_n++;
    check_eq("sat_refresh_total", 32'(ref_n), 32'd4);

    // Reset in the middle of a DMA access.
    do_reset();
    @(negedge clock); #1;
    dma_request = 1'b1; dma_write = 1'b0; dma_address = 20'h80200;
    hold_ack = 1'b1;
    wait_grants(1, 20, "abort_grant");
    repeat (2) @(negedge clock);
    #1;
    check_eq("abort_req_before", 32'(mem_request), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("abort_req_now", 32'(mem_request), 32'd0);
    check_eq("abort_busy_now", 32'(busy), 32'd0);
    dma_request = 1'b0;
    hold_ack = 1'b0;
    dma_rdy_cnt = 0;
    @(negedge clock); #1;
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("abort_no_dma_ready", 32'(dma_rdy_cnt), 32'd0);

    // DMA write leaves dma_data_out at the last read value.
    do_reset();
    dev_mem[int'(20'h80100)] = 8'h77;
    xfer(1'b1, 1'b0, 20'h80100, 8'h00, "dma_rd");
    check_eq("dma_rd_data", 32'(dma_data_out), 32'h77);
    xfer(1'b1, 1'b1, 20'h00400, 8'h5A, "dma_wr");
    check_eq("dma_wr_cmd_wr", 32'(grant_log[grant_log.size()-1].wr), 32'd1);
    check_eq("dma_wr_cmd_dat", 32'(grant_log[grant_log.size()-1].dat), 32'h5A);
    check_eq("dma_wr_cmd_addr", 32'(grant_log[grant_log.size()-1].addr), 32'h00400);
    check_eq("dma_wr_keeps_data", 32'(dma_data_out), 32'h77);
    check_eq("dma_wr_mem", 32'(dev_rd(20'h00400)), 32'h5A);

    // Randomized CPU/DMA traffic against the reference memory.
    do_reset();
    rand_mode = 1'b1;
    rand_lat  = 1'b1;
    cpu_last  = 8'h00;
    dma_last  = 8'h00;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic        wr;
          logic [19:0] a;
          logic [7:0]  d;
          wr = 1'($urandom_range(0, 1));
          a  = {16'h0000, 4'($urandom_range(0, 15))};
          d  = 8'($urandom_range(0, 255));
          repeat ($urandom_range(0, 3)) @(negedge clock);
          xfer(1'b0, wr, a, d, "rnd_cpu");
          if (wr) begin
            check_eq("rnd_cpu_wr_keeps", 32'(cpu_data_out), 32'(cpu_last));
            ref_mem[int'(a)] = d;
          end else begin
            cpu_last = ref_rd(a);
            check_eq("rnd_cpu_rd_data", 32'(cpu_data_out), 32'(cpu_last));
          end
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          logic        wr;
          logic [19:0] a;
          logic [7:0]  d;
          wr = 1'($urandom_range(0, 1));
          a  = {1'b1, 15'h0000, 4'($urandom_range(0, 15))};
          d  = 8'($urandom_range(0, 255));
          repeat ($urandom_range(0, 2)) @(negedge clock);
          xfer(1'b1, wr, a, d, "rnd_dma");
          if (wr) begin
            check_eq("rnd_dma_wr_keeps", 32'(dma_data_out), 32'(dma_last));
            ref_mem[int'(a)] = d;
          end else begin
            dma_last = ref_rd(a);
            check_eq("rnd_dma_rd_data", 32'(dma_data_out), 32'(dma_last));
          end
        end
      end
    join
    rand_mode = 1'b0;
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access_scheduler.md
MEMORY_ACCESS_SCHEDULER -- requirements
Module: memory_access_scheduler

Interface
REQ-001 Parameter REFRESH_INTERVAL, 72, clocks between refresh-request generations (≥2).
REQ-002 Parameter REFRESH_MAX_PENDING, 4, saturation limit of the pending-refresh counter (1..15).
REQ-003 Parameter DMA_BURST_LIMIT, 2, consecutive DMA grants allowed while CPU waits.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_request in 1, cpu_write in 1, cpu_address in 20, cpu_data_in in 8: CPU access request; level, held until cpu_ready.
REQ-007 cpu_ready out 1, cpu_data_out out 8: one-cycle completion pulse; read data.
REQ-008 dma_request in 1, dma_write in 1, dma_address in 20, dma_data_in in 8: DMA access request; same rules as CPU.
REQ-009 dma_ready out 1, dma_data_out out 8: DMA completion pulse; read data.
REQ-010 refresh_enable  in  1  enables the refresh interval counter.
REQ-011 mem_request out 1, mem_write out 1, mem_refresh out 1, mem_address out 20, mem_data_out out 8: memory port command.
REQ-012 mem_ack in 1, mem_data_in in 8: memory completion; read data valid in the same cycle as mem_ack.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 States: IDLE, CPU_ACCESS, DMA_ACCESS, REFRESH, COMPLETE.
REQ-015 In IDLE, the arbiter grants in this priority: (a) refresh if pending == REFRESH_MAX_PENDING; (b) CPU if cpu_request and dma_streak == DMA_BURST_LIMIT; (c) DMA; (d) CPU; (e) refresh if pending > 0; otherwise stay in IDLE.
REQ-016 On grant, the arbiter latches the winner's address, write flag and write data into the mem_* registers; mem_request = 1 from the next cycle (grant-to-request latency 1 clock).
REQ-017 The mem_* outputs hold stable while in an ACCESS or REFRESH state until mem_ack is sampled 1.
REQ-018 On the mem_ack cycle: mem_request deasserts next cycle; read data is captured into the owner's data_out; state goes to COMPLETE (for CPU or DMA) or IDLE (for refresh).
REQ-019 COMPLETE: the owner's ready = 1 for exactly one cycle, then IDLE; data_out holds until the next read completion for that owner.
REQ-020 Write completions also pulse ready; data_out is unchanged by writes.
REQ-021 dma_streak (2-bit): increments on each DMA grant while cpu_request = 1, saturating at DMA_BURST_LIMIT; clears on a CPU grant or whenever cpu_request = 0 in IDLE.
REQ-022 Refresh counter counts down while refresh_enable = 1; on reaching 0 it reloads REFRESH_INTERVAL-1 and increments pending (saturating; an overflow is dropped); when refresh_enable = 0 it holds.
REQ-023 A refresh cycle drives mem_refresh = 1, mem_write = 0, mem_address = {12'h0, refresh_row}; refresh_row (8-bit) increments on refresh ack, wrapping 0xFF->0x00.
REQ-024 pending decrements on refresh ack; a simultaneous increment and decrement leaves pending unchanged.
REQ-025 mem_data_out = 0 and mem_write = 0 on reads; mem_refresh = 0 outside REFRESH.
REQ-026 A request deasserted before grant is ignored; no ready pulse is issued for it.

Reset
REQ-027 reset_n = 0 forces state IDLE; all outputs 0 (including data_out buses); pending = 0; refresh_row = 0; dma_streak = 0; refresh counter = REFRESH_INTERVAL-1; this takes effect immediately, including mid-access.
REQ-028 After reset release, the first arbitration occurs on the first rising edge with reset_n = 1.

Verification
REQ-029 CPU read 0x12345, mem_ack on the 3rd request cycle with data 0xA5 -> mem_request for 3 cycles, cpu_ready pulse 1 cycle later, cpu_data_out = 0xA5, busy for 5 cycles.
REQ-030 CPU and DMA request in the same IDLE cycle, both held -> grant order DMA, DMA, CPU, DMA, DMA, CPU.
REQ-031 refresh_enable = 1 with no requests, REFRESH_INTERVAL = 72 -> one refresh every 72 clocks, mem_address = 0x00000, then 0x00001, and so on; row wraps after 256 refreshes.
REQ-032 Continuous DMA with mem_ack withheld for 300 clocks -> pending saturates at 4; next IDLE grants refresh ahead of DMA until pending < 4.
REQ-033 reset_n pulsed low while in DMA_ACCESS with mem_request = 1 -> mem_request = 0 and busy = 0 immediately; no dma_ready pulse.
REQ-034 DMA write of 0x5A to 0x00400 -> mem_write = 1, mem_data_out = 0x5A, dma_ready pulse, dma_data_out unchanged.
